ldm_stm_sequencer: RTL
======================

Name: ldm_stm_sequencer

Overview:
- Multi-register load/store sequencer for LDM/STM; sits directly upstream of the data memory file.
- Accepts one block-transfer request from decode and walks the 16-bit register list, lowest register first.
- Drives one memory word transfer per cycle: constant start address plus running index, with load/store enables and the matching register-file port.
- Then optionally writes back the updated base.

Parameters:
- ADDR_W, 8, word-address width of data memory and of base/index.
- NREGS, 16, register-file depth; reg_list width; register address width is log2(NREGS).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  request strobe; sampled only in IDLE
- is_load  in  1  1 = LDM, 0 = STM
- up  in  1  1 = increment, 0 = decrement
- pre  in  1  1 = before-mode (IB/DB), 0 = after-mode (IA/DA)
- wb  in  1  base writeback requested
- base_addr  in  ADDR_W  base register value (word address)
- reg_list  in  NREGS  register mask
- busy  out  1  high from accept until done cycle inclusive
- done  out  1  one-cycle pulse, request complete
- mem_addr  out  ADDR_W  start address, constant for whole request
- mem_i  out  ADDR_W  transfer index k
- ldr_str_en  out  1  memory access enable
- load_en  out  1  memory read enable
- store_en  out  1  memory write enable
- rf_addr  out  4  register being transferred (load target / store source)
- rf_we  out  1  register-file write for loaded word
- wb_we  out  1  base writeback strobe
- wb_data  out  ADDR_W  new base value

Behaviour:
- Reset: state IDLE; all outputs 0; latched request cleared. A reset mid-transfer aborts immediately with no further enables and no writeback.
- On accept, latch the request and compute N = popcount(reg_list).
- Start address S, computed modulo 2^ADDR_W:
  - IA: S = base
  - IB: S = base+1
  - DA: S = base-N+1
  - DB: S = base-N
- Writeback value, modulo 2^ADDR_W: up ? base+N : base-N.
- States: IDLE -> XFER -> (WB if wb) -> DONE -> IDLE.
- IDLE: start=1 accepts; goes to XFER, or to WB/DONE if N=0. start while not IDLE is ignored and not queued.
- XFER, cycle k = 0..N-1:
  - ldr_str_en=1; load_en=is_load; store_en=!is_load.
  - mem_addr=S; mem_i=k.
  - rf_addr = k-th set bit of the remaining mask, ascending; rf_we=is_load.
  - Clear that bit; leave after the last bit.
  - Lowest register always maps to the lowest address.
- WB: one cycle; wb_we=1, wb_data=writeback value. If is_load and reg_list includes the base register, the loaded value wins: wb_we is suppressed.
- DONE: done=1 for one cycle; enables 0; next state IDLE.
- Latency: start at cycle 0 -> first transfer cycle 1 -> done at cycle N+1, or N+2 with WB.
- N=0: no memory access; WB still runs if wb, with wb_data=base; done follows.
- Address wrap past 255 wraps silently.
- mem_addr, mem_i and rf_addr are held at their last values outside XFER, but enables are 0.

Optional Feature:
- Macro: LDM_PC_BRANCH_EN.
- Defined: adds output branch_req (1 bit). It pulses together with done when is_load=1 and reg_list[15]=1, telling fetch to redirect to the loaded r15.
- Undefined: no port; r15 is transferred like any other register.

Decomposition:
- Package cpu_seq_pkg holds:
  - seq_state_t enum (IDLE, XFER, WB, DONE)
  - constants ADDR_W and NREGS
  - the addressing-mode encoding {up,pre}
- Sub-module reg_list_scan: combinational find-first-set plus popcount over NREGS bits. Outputs lowest index, a valid flag and the count; used for both N and per-cycle selection.

Test Plan:
- STM IA, base=0x10, reg_list=0x000B, wb=1:
  - cycles 1-3: mem_addr=0x10, mem_i=0/1/2, rf_addr=0/1/3, store_en=1.
  - cycle 4: wb_data=0x13.
  - cycle 5: done.
- LDM DB, base=0x20, reg_list=0x8001, wb=0:
  - mem_addr=0x1E; rf_addr=0 then 15; rf_we=1 both cycles.
  - done at cycle 3; with LDM_PC_BRANCH_EN, branch_req=1 in the same cycle.
- Empty list, wb=1, base=0x40, up=1 -> no ldr_str_en; wb_data=0x40; done at cycle 2.
- DA wrap, base=0x01, reg_list=0x000F -> mem_addr=0xFE; mem_i 0..3.
- LDM with base reg in list, reg_list=0x0006, wb=1 -> wb_we stays 0; done at cycle 3.
- rst asserted in 2nd XFER cycle of a 4-register STM -> next cycle all enables 0, busy=0, no done; a new start is accepted afterwards.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
package cpu_seq_pkg;

  localparam int ADDR_W   = 8;
  localparam int NREGS    = 16;
  localparam int RF_AW    = $clog2(NREGS);
  localparam int CNT_W    = $clog2(NREGS + 1);
  // The base register is fixed by the ISA encoding this core uses.
  localparam int BASE_REG = 1;

  typedef enum logic [1:0] {IDLE, XFER, WB, DONE} seq_state_t;

  // Addressing mode encoded as {up, pre}.
  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_DB = 2'b01,
    MODE_IA = 2'b10,
    MODE_IB = 2'b11
  } addr_mode_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  function automatic logic [ADDR_W-1:0] calc_start(input addr_mode_t mode,
                                                   input logic [ADDR_W-1:0] base,
                                                   input logic [CNT_W-1:0] n);
    logic [ADDR_W-1:0] n_ext;
    n_ext = ADDR_W'(n);
    case (mode)
      MODE_IA: calc_start = base;
      MODE_IB: calc_start = base + ADDR_ONE;
      MODE_DA: calc_start = base - n_ext + ADDR_ONE;
      default: calc_start = base - n_ext;
    endcase
  endfunction

endpackage

// File: rtl/reg_list_scan.sv
// Combinational find-first-set and popcount over a register mask.
module reg_list_scan
  import cpu_seq_pkg::*;
(
  input  logic [NREGS-1:0] mask,
  output logic [RF_AW-1:0] first_idx,
  output logic             any_set,
  output logic [CNT_W-1:0] count
);

  // Descending walk so the lowest set bit is the last one written.
  always_comb begin
    first_idx = '0;
    any_set   = 1'b0;
    count     = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first_idx = RF_AW'(i);
        any_set   = 1'b1;
        count     = count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: walks a register list, one memory word per cycle, then optional base writeback.
// Optional feature macro: LDM_PC_BRANCH_EN adds branch_req for loads that include r15.
module ldm_stm_sequencer
  import cpu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic              up,
  input  logic              pre,
  input  logic              wb,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [NREGS-1:0]  reg_list,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_i,
  output logic              ldr_str_en,
  output logic              load_en,
  output logic              store_en,
  output logic [RF_AW-1:0]  rf_addr,
  output logic              rf_we,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_data
`ifdef LDM_PC_BRANCH_EN
  ,
  output logic              branch_req
`endif
);

  seq_state_t        state_q, state_d;
  logic [NREGS-1:0]  mask_q;
  logic              is_load_q;
  logic              wb_eff_q;
  logic [ADDR_W-1:0] wb_val_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] idx_q;
  logic [RF_AW-1:0]  rf_last_q;

  logic [RF_AW-1:0]  req_first;
  logic              req_any;
  logic [CNT_W-1:0]  req_count;
  logic [RF_AW-1:0]  cur_first;
  logic              cur_any;
  logic [CNT_W-1:0]  cur_count;
  logic              req_wb_eff;
  logic              in_xfer;

  reg_list_scan u_req_scan (
    .mask      (reg_list),
    .first_idx (req_first),
    .any_set   (req_any),
    .count     (req_count)
  );

  reg_list_scan u_cur_scan (
    .mask      (mask_q),
    .first_idx (cur_first),
    .any_set   (cur_any),
    .count     (cur_count)
  );

  // A load that overwrites the base register makes the loaded value win.
  assign req_wb_eff = wb && !(is_load && reg_list[BASE_REG]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (req_any)         state_d = XFER;
          else if (req_wb_eff) state_d = WB;
          else                 state_d = DONE;
        end
      end
      XFER: begin
        if (cur_count <= CNT_W'(1)) state_d = wb_eff_q ? WB : DONE;
      end
      WB:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_xfer    = (state_q == XFER);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign ldr_str_en = in_xfer;
  assign load_en    = in_xfer && is_load_q;
  assign store_en   = in_xfer && !is_load_q;
  assign rf_we      = in_xfer && is_load_q;
  assign rf_addr    = (in_xfer && cur_any) ? cur_first : rf_last_q;
  assign mem_addr   = addr_q;
  assign mem_i      = idx_q;
  assign wb_we      = (state_q == WB);
  assign wb_data    = wb_we ? wb_val_q : '0;

`ifdef LDM_PC_BRANCH_EN
  logic branch_q;
  assign branch_req = done && branch_q;
`endif

  // Address/index/register outputs only move while transferring, so they hold afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      is_load_q <= 1'b0;
      wb_eff_q  <= 1'b0;
      wb_val_q  <= '0;
      addr_q    <= '0;
      idx_q     <= '0;
      rf_last_q <= '0;
`ifdef LDM_PC_BRANCH_EN
      branch_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            mask_q    <= reg_list;
            is_load_q <= is_load;
            wb_eff_q  <= req_wb_eff;
            wb_val_q  <= up ? (base_addr + ADDR_W'(req_count))
                            : (base_addr - ADDR_W'(req_count));
`ifdef LDM_PC_BRANCH_EN
            branch_q  <= is_load && reg_list[NREGS-1];
`endif
            if (req_any) begin
              addr_q <= calc_start(addr_mode_t'({up, pre}), base_addr, req_count);
              idx_q  <= '0;
            end
          end
        end
        XFER: begin
          mask_q[cur_first] <= 1'b0;
          rf_last_q         <= cur_first;
          if (cur_count > CNT_W'(1)) idx_q <= idx_q + ADDR_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule
